// File: rtl/mips.sv
// mips: board top for the 32-bit ALU console.
// Operands come from the DIP switches and the operation from the push keys.
// The result is shown on the LEDs and on a multiplexed seven-segment display.
// Optional UART echo of result[7:0] is built only with MIPS_UART_EN defined.
// All board-side inputs and outputs are active-low.
module mips #(
  parameter int SCAN_DIV = 32768,
  parameter int BAUD_DIV = 868
) (
  input  logic        clk_in,
  input  logic        sys_rstn,
  input  logic        uart_rxd,
  output logic        uart_txd,
  input  logic [7:0]  dip_switch0,
  input  logic [7:0]  dip_switch1,
  input  logic [7:0]  dip_switch2,
  input  logic [7:0]  dip_switch3,
  input  logic [7:0]  dip_switch4,
  input  logic [7:0]  dip_switch5,
  input  logic [7:0]  dip_switch6,
  input  logic [7:0]  dip_switch7,
  input  logic [7:0]  user_key,
  output logic [31:0] led_light,
  output logic [7:0]  digital_tube0,
  output logic [3:0]  digital_tube_sel0,
  output logic [7:0]  digital_tube1,
  output logic [3:0]  digital_tube_sel1,
  output logic [7:0]  digital_tube2,
  output logic        digital_tube_sel2
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Seven-segment code (active-low, dp off) for one hex digit.
  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] c;
    case (n)
      4'h0: c = 8'hC0;  4'h1: c = 8'hF9;  4'h2: c = 8'hA4;  4'h3: c = 8'hB0;
      4'h4: c = 8'h99;  4'h5: c = 8'h92;  4'h6: c = 8'h82;  4'h7: c = 8'hF8;
      4'h8: c = 8'h80;  4'h9: c = 8'h90;  4'hA: c = 8'h88;  4'hB: c = 8'h83;
      4'hC: c = 8'hC6;  4'hD: c = 8'hA1;  4'hE: c = 8'h86;  4'hF: c = 8'h8E;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  // Nibble i of a 16-bit half-word.
  function automatic logic [3:0] nib(input logic [15:0] h, input logic [1:0] i);
    logic [3:0] n;
    case (i)
      2'd0: n = h[3:0];
      2'd1: n = h[7:4];
      2'd2: n = h[11:8];
      2'd3: n = h[15:12];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  // The receive line is intentionally not used by this console.
  logic unused_rxd_s;
  assign unused_rxd_s = uart_rxd;

  logic [31:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic [7:0]  k_s1_q, k_s2_q;

  logic [31:0] result_q, result_d;
  logic [2:0]  op_q, op_d;
  logic        op_valid_q, op_valid_d;
  logic [1:0]  dig_q, dig_d;
  logic [SW-1:0] scan_q, scan_d;

  logic [31:0] led_q;
  logic [7:0]  tube0_q, tube1_q, tube2_q;
  logic [3:0]  sel_q;

  logic        key_any_s;
  logic [2:0]  key_op_s;
  logic [31:0] alu_s;
  logic [3:0]  sel_d;

  // Two-flop synchronizers on the inverted (active-high) board inputs.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      a_s1_q <= 32'h0; a_s2_q <= 32'h0;
      b_s1_q <= 32'h0; b_s2_q <= 32'h0;
      k_s1_q <= 8'h0;  k_s2_q <= 8'h0;
    end else begin
      a_s1_q <= ~{dip_switch7, dip_switch6, dip_switch5, dip_switch4};
      b_s1_q <= ~{dip_switch3, dip_switch2, dip_switch1, dip_switch0};
      k_s1_q <= ~user_key;
      a_s2_q <= a_s1_q;
      b_s2_q <= b_s1_q;
      k_s2_q <= k_s1_q;
    end
  end

  // Lowest-index pressed key selects the operation.
  always_comb begin
    key_any_s = 1'b1;
    key_op_s  = 3'd0;
    casez (k_s2_q)
      8'b???????1: key_op_s = 3'd0;
      8'b??????10: key_op_s = 3'd1;
      8'b?????100: key_op_s = 3'd2;
      8'b????1000: key_op_s = 3'd3;
      8'b???10000: key_op_s = 3'd4;
      8'b??100000: key_op_s = 3'd5;
      8'b?1000000: key_op_s = 3'd6;
      8'b10000000: key_op_s = 3'd7;
      default: begin
        key_any_s = 1'b0;
        key_op_s  = 3'd0;
      end
    endcase
  end

  // The ALU itself; all arithmetic wraps modulo 2^32.
  always_comb begin
    alu_s = 32'h0;
    case (key_op_s)
      3'd0: alu_s = a_s2_q + b_s2_q;
      3'd1: alu_s = a_s2_q - b_s2_q;
      3'd2: alu_s = a_s2_q & b_s2_q;
      3'd3: alu_s = a_s2_q | b_s2_q;
      3'd4: alu_s = a_s2_q ^ b_s2_q;
      3'd5: alu_s = ~(a_s2_q | b_s2_q);
      3'd6: alu_s = a_s2_q << b_s2_q[4:0];
      3'd7: alu_s = a_s2_q >> b_s2_q[4:0];
      default: alu_s = 32'h0;
    endcase
  end

  // Next state: result/op reload while a key is held, scan index steps every SCAN_DIV cycles.
  always_comb begin
    result_d   = result_q;
    op_d       = op_q;
    op_valid_d = op_valid_q;
    scan_d     = scan_q;
    dig_d      = dig_q;
    if (key_any_s) begin
      result_d   = alu_s;
      op_d       = key_op_s;
      op_valid_d = 1'b1;
    end else begin
      result_d   = result_q;
    end
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = {SW{1'b0}};
      dig_d  = dig_q + 2'd1;
    end else begin
      scan_d = scan_q + {{(SW-1){1'b0}}, 1'b1};
    end
    sel_d = ~(4'b0001 << dig_d);
  end

  // Result, op and display registers; outputs are decoded from next-state so they move with their sources.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      result_q   <= 32'h0;
      op_q       <= 3'd0;
      op_valid_q <= 1'b0;
      scan_q     <= {SW{1'b0}};
      dig_q      <= 2'd0;
      led_q      <= 32'hFFFF_FFFF;
      sel_q      <= 4'b1110;
      tube0_q    <= 8'hC0;
      tube1_q    <= 8'hC0;
      tube2_q    <= 8'hFF;
    end else begin
      result_q   <= result_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      scan_q     <= scan_d;
      dig_q      <= dig_d;
      led_q      <= ~result_d;
      sel_q      <= sel_d;
      tube0_q    <= hex7(nib(result_d[15:0], dig_d));
      tube1_q    <= hex7(nib(result_d[31:16], dig_d));
      tube2_q    <= op_valid_d ? hex7({1'b0, op_d}) : 8'hFF;
    end
  end

  assign led_light         = led_q;
  assign digital_tube0     = tube0_q;
  assign digital_tube1     = tube1_q;
  assign digital_tube2     = tube2_q;
  assign digital_tube_sel0 = sel_q;
  assign digital_tube_sel1 = sel_q;
  assign digital_tube_sel2 = 1'b0;

`ifdef MIPS_UART_EN
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  tx_state_e   tx_state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic [7:0]  pend_byte_q;
  logic        pend_q;
  logic        tx_q;
  logic        new_byte_s;
  logic        baud_end_s;

  assign new_byte_s = key_any_s && (alu_s != result_q);
  assign baud_end_s = (baud_q == BW'(BAUD_DIV - 1));

  // 8N1 transmitter with a one-byte overwrite queue; a running frame always completes.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      tx_state_q  <= TX_IDLE;
      baud_q      <= {BW{1'b0}};
      bit_q       <= 3'd0;
      shift_q     <= 8'h0;
      pend_byte_q <= 8'h0;
      pend_q      <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          baud_q <= {BW{1'b0}};
          if (pend_q) begin
            shift_q    <= pend_byte_q;
            pend_q     <= 1'b0;
            tx_q       <= 1'b0;
            tx_state_q <= TX_START;
          end else begin
            tx_q <= 1'b1;
          end
        end
        TX_START: begin
          if (baud_end_s) begin
            baud_q     <= {BW{1'b0}};
            tx_q       <= shift_q[0];
            shift_q    <= {1'b0, shift_q[7:1]};
            bit_q      <= 3'd0;
            tx_state_q <= TX_DATA;
          end else begin
            baud_q <= baud_q + {{(BW-1){1'b0}}, 1'b1};
          end
        end
        TX_DATA: begin
          if (baud_end_s) begin
            baud_q <= {BW{1'b0}};
            if (bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + {{(BW-1){1'b0}}, 1'b1};
          end
        end
        TX_STOP: begin
          if (baud_end_s) begin
            baud_q <= {BW{1'b0}};
            if (pend_q) begin
              shift_q    <= pend_byte_q;
              pend_q     <= 1'b0;
              tx_q       <= 1'b0;
              tx_state_q <= TX_START;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            baud_q <= baud_q + {{(BW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_q       <= 1'b1;
        end
      endcase
      // A fresh result byte overrides whatever the frame logic did to the queue.
      if (new_byte_s) begin
        pend_q      <= 1'b1;
        pend_byte_q <= alu_s[7:0];
      end
    end
  end

  assign uart_txd = tx_q;
`else
  assign uart_txd = 1'b1;
`endif

endmodule

// File: tb/tb_mips.sv
// Directed self-checking bench for mips (SCAN_DIV = 4, BAUD_DIV = 4).
module tb_mips;

  logic        clk_in = 1'b0;
  logic        sys_rstn;
  logic        uart_rxd;
  logic        uart_txd;
  logic [7:0]  dip_switch0, dip_switch1, dip_switch2, dip_switch3;
  logic [7:0]  dip_switch4, dip_switch5, dip_switch6, dip_switch7;
  logic [7:0]  user_key;
  logic [31:0] led_light;
  logic [7:0]  digital_tube0, digital_tube1, digital_tube2;
  logic [3:0]  digital_tube_sel0, digital_tube_sel1;
  logic        digital_tube_sel2;

  int tests = 0;
  int fails = 0;

  mips #(.SCAN_DIV(4), .BAUD_DIV(4)) dut (
    .clk_in(clk_in), .sys_rstn(sys_rstn), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .dip_switch0(dip_switch0), .dip_switch1(dip_switch1),
    .dip_switch2(dip_switch2), .dip_switch3(dip_switch3),
    .dip_switch4(dip_switch4), .dip_switch5(dip_switch5),
    .dip_switch6(dip_switch6), .dip_switch7(dip_switch7),
    .user_key(user_key), .led_light(led_light),
    .digital_tube0(digital_tube0), .digital_tube_sel0(digital_tube_sel0),
    .digital_tube1(digital_tube1), .digital_tube_sel1(digital_tube_sel1),
    .digital_tube2(digital_tube2), .digital_tube_sel2(digital_tube_sel2)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    {dip_switch7, dip_switch6, dip_switch5, dip_switch4} = ~a;
    {dip_switch3, dip_switch2, dip_switch1, dip_switch0} = ~b;
  endtask

  logic [31:0] exp_res [8];
  logic [7:0]  exp_op7 [8];
  logic [7:0]  exp_t0 [4];
  logic [7:0]  exp_t1 [4];
  logic [3:0]  exp_sel [4];
  logic        frame [10];
  int          guard;
  int          zeros;

  initial begin
    exp_res = '{32'h0000000F, 32'hFFFFFFF7, 32'h0, 32'hF, 32'hF, 32'hFFFFFFF0, 32'h00003000, 32'h0};
    exp_op7 = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    exp_t0  = '{8'h80, 8'hF8, 8'h82, 8'h92};
    exp_t1  = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    exp_sel = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    frame   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset with everything released.
    sys_rstn = 1'b0;
    uart_rxd = 1'b1;
    user_key = 8'hFF;
    set_ops(32'h0, 32'h0);
    #22;
    check("rst_led", led_light, 32'hFFFFFFFF);
    check("rst_tube2", {24'h0, digital_tube2}, 32'hFF);
    check("rst_sel0", {28'h0, digital_tube_sel0}, 32'hE);
    check("rst_sel1", {28'h0, digital_tube_sel1}, 32'hE);
    check("rst_tube0", {24'h0, digital_tube0}, 32'hC0);
    check("rst_tube1", {24'h0, digital_tube1}, 32'hC0);
    check("rst_sel2", {31'h0, digital_tube_sel2}, 32'h0);
    check("rst_txd", {31'h0, uart_txd}, 32'h1);

    // Release reset, A = 3, B = 12; verify two-cycle input latency with key0.
    tick(1);
    sys_rstn = 1'b1;
    set_ops(32'd3, 32'd12);
    tick(3);
    user_key = 8'hFE;
    tick(2);
    check("lat_n1", led_light, 32'hFFFFFFFF);
    tick(1);
    check("lat_n2", led_light, ~32'h0000000F);

    // Every key in turn, then release and confirm the value holds.
    for (int k = 0; k < 8; k++) begin
      user_key = ~(8'h01 << k);
      tick(k < 2 ? 1000 : 10);
      check($sformatf("key%0d_led", k), led_light, ~exp_res[k]);
      check($sformatf("key%0d_op", k), {24'h0, digital_tube2}, {24'h0, exp_op7[k]});
      user_key = 8'hFF;
      tick(10);
      check($sformatf("hold%0d_led", k), led_light, ~exp_res[k]);
      check($sformatf("hold%0d_op", k), {24'h0, digital_tube2}, {24'h0, exp_op7[k]});
    end

    // Keys 1 and 4 together: subtract wins; B changes live.
    user_key = ~8'h12;
    tick(5);
    check("multi_led", led_light, ~32'hFFFFFFF7);
    check("multi_op", {24'h0, digital_tube2}, 32'hF9);
    set_ops(32'd3, 32'd1);
    tick(3);
    check("live_led", led_light, ~32'h00000002);
    user_key = 8'hFF;

    // Display scan with result 0x12345678.
    set_ops(32'h12345678, 32'h0);
    user_key = 8'hFE;
    tick(5);
    user_key = 8'hFF;
    tick(3);
    check("scan_led", led_light, ~32'h12345678);
    guard = 0;
    while (digital_tube_sel0 != 4'b0111 && guard < 40) begin tick(1); guard++; end
    while (digital_tube_sel0 == 4'b0111 && guard < 40) begin tick(1); guard++; end
    check("scan_sync", {31'h0, guard < 40}, 32'h1);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("sel0_d%0d", d), {28'h0, digital_tube_sel0}, {28'h0, exp_sel[d]});
      check($sformatf("sel1_d%0d", d), {28'h0, digital_tube_sel1}, {28'h0, exp_sel[d]});
      check($sformatf("tube0_d%0d", d), {24'h0, digital_tube0}, {24'h0, exp_t0[d]});
      check($sformatf("tube1_d%0d", d), {24'h0, digital_tube1}, {24'h0, exp_t1[d]});
      tick(3);
      check($sformatf("sel0_late_d%0d", d), {28'h0, digital_tube_sel0}, {28'h0, exp_sel[d]});
      check($sformatf("tube0_late_d%0d", d), {24'h0, digital_tube0}, {24'h0, exp_t0[d]});
      tick(1);
    end
    check("txd_idle", {31'h0, uart_txd}, 32'h1);

`ifdef MIPS_UART_EN
    // Fresh reset, then key0 with A = 3, B = 12 sends exactly one 0x0F frame.
    sys_rstn = 1'b0;
    user_key = 8'hFF;
    set_ops(32'd3, 32'd12);
    tick(2);
    sys_rstn = 1'b1;
    tick(2);
    user_key = 8'hFE;
    guard = 0;
    while (uart_txd !== 1'b0 && guard < 40) begin tick(1); guard++; end
    check("uart_start_seen", {31'h0, guard < 40}, 32'h1);
    tick(2);
    for (int b = 0; b < 10; b++) begin
      check($sformatf("uart_bit%0d", b), {31'h0, uart_txd}, {31'h0, frame[b]});
      tick(4);
    end
    zeros = 0;
    for (int c = 0; c < 100; c++) begin
      if (uart_txd !== 1'b1) zeros++;
      tick(1);
    end
    check("uart_no_repeat", zeros, 32'd0);

    // New result starts a frame; reset in the middle forces the line idle.
    user_key = 8'hFD;
    guard = 0;
    while (uart_txd !== 1'b0 && guard < 40) begin tick(1); guard++; end
    check("uart_start2_seen", {31'h0, guard < 40}, 32'h1);
    tick(6);
    sys_rstn = 1'b0;
    #1;
    check("uart_rst_txd", {31'h0, uart_txd}, 32'h1);
    user_key = 8'hFF;
    tick(2);
    sys_rstn = 1'b1;
    tick(20);
    check("uart_after_rst", {31'h0, uart_txd}, 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
